// File: rtl/stream_arb_2_1.sv
// Two-input valid/ready stream arbiter with packet-locked round-robin grant
// and a single-stage registered output feeding one downstream consumer.
module stream_arb_2_1 #(
  parameter int WIDTH   = 8,
  parameter bit LOCK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  output logic             y_last,
  input  logic             y_ready,
  output logic             s,
  output logic             busy
);

  // Handshake: a beat moves on any edge where x_valid & x_ready are both 1;
  // the output register moves a beat downstream when y_valid & y_ready.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             pri_q, pri_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_valid_q, y_valid_d;
  logic             y_last_q, y_last_d;

  logic gnt_a, gnt_b, sel, load;
  logic acc_a, acc_b, acc, acc_last;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    sel   = pri_q;
    case (state_q)
      IDLE: begin
        gnt_a = a_valid & (~b_valid | ~pri_q);
        gnt_b = b_valid & (~a_valid | pri_q);
        if (gnt_a)      sel = 1'b0;
        else if (gnt_b) sel = 1'b1;
      end
      LOCK_A: begin
        gnt_a = 1'b1;
        sel   = 1'b0;
      end
      LOCK_B: begin
        gnt_b = 1'b1;
        sel   = 1'b1;
      end
      default: ;
    endcase
  end

  // Readies are forced low while reset is asserted.
  assign load     = ~y_valid_q | y_ready;
  assign a_ready  = rst_n & load & gnt_a;
  assign b_ready  = rst_n & load & gnt_b;
  assign acc_a    = a_valid & a_ready;
  assign acc_b    = b_valid & b_ready;
  assign acc      = acc_a | acc_b;
  assign acc_last = acc_b ? b_last : a_last;

  always_comb begin
    state_d   = state_q;
    pri_d     = pri_q;
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    if (acc) begin
      y_data_d  = acc_b ? b_data : a_data;
      y_last_d  = acc_last;
      y_valid_d = 1'b1;
      if (LOCK_EN) begin
        if (acc_last) begin
          state_d = IDLE;
          pri_d   = acc_a;
        end else begin
          state_d = acc_a ? LOCK_A : LOCK_B;
        end
      end else begin
        pri_d = acc_a;
      end
    end else if (y_valid_q & y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pri_q     <= 1'b0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pri_q     <= pri_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
  assign y_last  = y_last_q;
  assign s       = sel;
  assign busy    = (state_q != IDLE) | y_valid_q;

endmodule

// File: doc/stream_arb_2_1.md
Name: stream_arb_2_1

Overview:
- Two-input valid/ready stream arbiter that feeds the 2:1 mux datapath.
- Generates the mux select `s` (0 = a, 1 = b) using packet-locked round-robin arbitration.
- Registers the selected beat into a single-stage output register.
- Sits between two upstream producers and one downstream consumer; merges packets without interleaving beats of different packets.

Parameters:
- WIDTH, 8, data width of a_data, b_data, y_data.
- LOCK_EN, 1, 1 = hold grant until the accepted beat has last=1; 0 = re-arbitrate every beat, last is passed through only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a_data  input  WIDTH  source A beat data.
- a_valid  input  1  source A beat valid.
- a_last  input  1  source A final beat of packet.
- a_ready  output  1  source A beat accepted this cycle when a_valid&a_ready.
- b_data  input  WIDTH  source B beat data.
- b_valid  input  1  source B beat valid.
- b_last  input  1  source B final beat of packet.
- b_ready  output  1  source B accept.
- y_data  output  WIDTH  registered output data.
- y_valid  output  1  registered output valid.
- y_last  output  1  registered output last.
- y_ready  input  1  downstream accept.
- s  output  1  mux select: 0 = a, 1 = b; combinational from current grant.
- busy  output  1  1 while in a LOCK state or y_valid=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pri=0 (A favoured), y_valid=0, y_last=0, y_data=0. a_ready=b_ready=0 while in reset. Deassertion is taken synchronously by the next clk edge.
- load = !y_valid | y_ready. The output register accepts a new beat when load=1, so a simultaneous drain and fill gives full throughput of 1 beat/cycle.
- Latency: a beat accepted at edge N appears on y_* after edge N (one cycle); there is no combinational path from inputs to y_*.
- States:
  - IDLE: grant = A if a_valid & (!b_valid | pri==0); B if b_valid & (!a_valid | pri==1); none otherwise.
  - LOCK_A: grant = A only.
  - LOCK_B: grant = B only.
- s = grant (A→0, B→1). With no grant in IDLE, s = pri. In LOCK_A s=0, in LOCK_B s=1, regardless of valids.
- a_ready = load & (grant==A); b_ready = load & (grant==B). Never both 1. The ungranted ready is 0.
- Transfer: on accept, y_data <= (s ? b_data : a_data), y_last <= accepted last, y_valid <= 1.
- When y_valid & y_ready and there is no accept: y_valid <= 0, and y_data/y_last hold.
- Transitions (LOCK_EN=1):
  - IDLE → LOCK_x on an accepted beat with last=0.
  - IDLE stays IDLE on an accepted beat with last=1, and pri <= !x.
  - LOCK_x → IDLE on an accepted beat with last=1, and pri <= !x.
  - LOCK_x holds otherwise, including while x_valid=0 (bubbles inside a packet do not release the lock).
- LOCK_EN=0: the FSM never leaves IDLE; pri <= !x after every accepted beat.
- pri changes only on a packet-ending accept (or every accept when LOCK_EN=0), never on stall cycles.
- Backpressure: with y_valid=1 and y_ready=0, both readies are 0, and y_data/y_valid/y_last are held stable.
- Single-beat packets from both sources with both valid alternate A,B,A,B...
- Reset mid-packet discards the lock and the output register contents. The first grant after reset goes to A if both are valid.
- Inputs are not required to hold data when valid & !ready; the arbiter samples only on accept.

Test Plan:
- Reset with a_valid=b_valid=1, 1-beat packets a_data=0x11, b_data=0x22, y_ready=1 → y_data sequence 0x11,0x22,0x11,0x22; s toggles 0,1,0,1; y_valid continuous from the 2nd cycle.
- A sends a 3-beat packet 0xA0,0xA1,0xA2(last) while b_valid=1 throughout → y shows A0,A1,A2 contiguous, b_ready=0 for those 3 cycles, then B granted; a_valid gap of 2 cycles mid-packet keeps LOCK_A and s=0.
- y_ready=0 for 4 cycles with a beat 0x5C held → y_data=0x5C and y_valid=1 stable, a_ready=b_ready=0; on y_ready=1, 0x5C drains and the next beat loads at the same edge.
- Only b_valid with pri=0 → B granted immediately (s=1); after its last beat pri=0, so the next simultaneous request goes to A.
- Assert rst_n=0 in the middle of a B packet (LOCK_B) → y_valid=0 immediately (async); after release, both valid → A granted first.
- LOCK_EN=0, both sending 2-beat packets → beats interleave A0,B0,A1,B1, with y_last passed through per beat.
